mux4_rr_sched: RTL and testbench
================================

MUX4_RR_SCHED -- requirements
Module: mux4_rr_sched

Interface
REQ-001 Parameter LEN_W, default 4: width of the burst-length input and beat counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-requester request; bit i high = requester i has a beat ready this cycle.
REQ-005 burst_len  input  LEN_W  beats per grant; sampled only at grant start; 0 is treated as 1.
REQ-006 gnt  output  4  registered one-hot grant; all-zero when no grant.
REQ-007 sel  output  2  registered channel select driven to the 4-channel registered mux.
REQ-008 busy  output  1  high while state is BURST.
REQ-009 out_valid  output  1  high in the cycle the mux output holds a consumed beat.
REQ-010 out_ch  output  2  requester index of the beat flagged by out_valid.
REQ-011 out_last  output  1  high with out_valid on the final beat of a burst, completed or abandoned.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and BURST.
- IDLE, req==0: SHALL remain in IDLE; gnt=0; sel holds its previous value.
- IDLE, req!=0: SHALL pick the winner idx round-robin in order last+1, last+2, last+3, last (mod 4).
- On that edge: SHALL enter BURST; gnt=onehot(idx); sel=idx; remaining = max(burst_len,1); last=idx.
REQ-013 In BURST, a beat SHALL occur in every cycle where req[idx]=1; each beat decrements remaining by 1.
REQ-014 The final beat (remaining==1) SHALL return the FSM to IDLE with gnt=0 on the next edge.
REQ-015 If req[idx]=0 in BURST: no beat; SHALL abandon the burst and go to IDLE next edge.
REQ-016 If a burst is abandoned, the previous beat's out_valid entry SHALL NOT be retro-flagged out_last.
REQ-017 Abandonment SHALL instead be reported by out_last=0 throughout the burst; out_last on an abandoned burst SHALL never assert.
REQ-018 Every burst SHALL be followed by at least one IDLE cycle (one-cycle bubble); no back-to-back grants.
REQ-019 Requests from non-granted channels during BURST SHALL be ignored until IDLE; no preemption.
REQ-020 sel SHALL change only on grant start and SHALL equal idx for the whole burst.
REQ-021 out_valid/out_ch/out_last SHALL be the beat/idx/final-beat flags delayed by exactly one cycle.
- This matches the mux's one-cycle registered latency.
REQ-022 Changes to burst_len during BURST SHALL have no effect on the current burst.
REQ-023 Worst-case wait for a continuously requesting channel SHALL be 3 bursts plus 3 bubbles.

Reset
REQ-024 With rst high at an edge, the block SHALL set: state=IDLE, gnt=0, sel=0, busy=0, out_valid=0, out_ch=0, out_last=0, remaining=0, last=3.
- last=3 means req[0] has priority first.
REQ-025 Reset mid-burst SHALL abandon the burst with no out_last.
- out_valid SHALL be 0 in the cycle after the reset edge, even if a beat occurred in the cycle before.
REQ-026 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-027 Shared package fft_pkg SHALL hold the state type {IDLE, BURST} and the LEN_W default constant.
REQ-028 The round-robin pick SHALL be a combinational sub-module rr_pick4.
- Inputs: req[3:0], last[1:0]. Outputs: any, idx[1:0].
- The FSM/counter/output pipeline SHALL reside in mux4_rr_sched.

Verification
REQ-029 Reset release, req=0001, burst_len=3 -> gnt=0001 and sel=0 from cycle 1; beats in cycles 1-3; out_valid in cycles 2-4, out_last in cycle 4; busy low in cycle 4.
REQ-030 req=1111 held, burst_len=1 -> grant order 0,1,2,3,0 with one IDLE bubble between grants; sel tracks the grant order.
REQ-031 req=0100, burst_len=4, req[2] dropped in the 2nd BURST cycle -> exactly 1 out_valid pulse, no out_last; IDLE next cycle.
REQ-032 burst_len=0, req=1000 -> single-beat burst on channel 3 with out_last=1.
- Then change burst_len to 5 during a fresh burst -> that burst's length is unaffected.
REQ-033 rst asserted in the 2nd beat of a 4-beat burst on channel 1 -> next cycle: all outputs 0, sel=0.
- With req=0011 afterwards, channel 0 is granted first.
REQ-034 req=0010 in BURST of channel 0 with burst_len=2 -> channel 1 is not granted until after the bubble; there is no overlap on sel.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the 4-way round-robin burst scheduler.
package fft_pkg;

    localparam int LEN_W_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic logic [3:0] onehot4(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, last.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       any,
    output logic [1:0] idx
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        any   = |req;
        idx   = last;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Burst scheduler for a 4-channel registered mux: two-state FSM,
// beat counter and a one-cycle delayed beat/channel/last pipeline.
module mux4_rr_sched
    import fft_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [LEN_W-1:0] burst_len,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             out_valid,
    output logic [1:0]       out_ch,
    output logic             out_last
);

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_ch_q, out_ch_d;
    logic             out_last_q, out_last_d;

    logic             pick_any;
    logic [1:0]       pick_idx;
    logic             beat;
    logic             fin;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        rem_d   = rem_q;
        beat    = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BURST;
                    gnt_d   = onehot4(pick_idx);
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    rem_d   = (burst_len == '0) ? LEN_W'(1) : burst_len;
                end
            end
            BURST: begin
                // sel_q holds the granted index for the whole burst
                if (req[sel_q]) begin
                    beat  = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    rem_d   = '0;
                end
            end
        endcase
        out_valid_d = beat;
        out_ch_d    = beat ? sel_q : out_ch_q;
        out_last_d  = fin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            last_q      <= 2'd3;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = (state_q == BURST);
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: inputs change and outputs are
// sampled on the falling edge, state moves on the rising edge.
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] burst_len;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       out_valid;
    logic [1:0] out_ch;
    logic       out_last;

    int total  = 0;
    int passed = 0;
    int nvalid;
    int nlast;

    logic [3:0] exp_gnt [1:9];
    logic [1:0] exp_sel [1:9];

    mux4_rr_sched #(.LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .burst_len (burst_len),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g,
                           input logic [1:0] s, input logic b,
                           input logic v, input logic [1:0] c,
                           input logic l);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".sel"}, 32'(sel), 32'(s));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".ov"}, 32'(out_valid), 32'(v));
        chk({tag, ".och"}, 32'(out_ch), 32'(c));
        chk({tag, ".olast"}, 32'(out_last), 32'(l));
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        burst_len = 4'd0;
        step();
        step();
        chk_out("reset", 4'h0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

        // single requester, 3-beat burst from reset
        rst = 1'b0;
        req = 4'b0001;
        burst_len = 4'd3;
        step();
        chk_out("a.c1", 4'h1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        step();
        chk_out("a.c2", 4'h1, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk_out("a.c3", 4'h1, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk_out("a.c4", 4'h0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1);
        req = 4'b0000;
        step();
        chk_out("a.c5", 4'h0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

        // all requesting, single-beat bursts: 0,1,2,3,0 with bubbles
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        burst_len = 4'd1;
        exp_gnt = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        exp_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("b.gnt%0d", i), 32'(gnt), 32'(exp_gnt[i]));
            chk($sformatf("b.sel%0d", i), 32'(sel), 32'(exp_sel[i]));
            chk($sformatf("b.ov%0d", i), 32'(out_valid),
                32'((i % 2 == 0) ? 1 : 0));
        end
        req = 4'b0000;
        step();
        step();
        chk("b.idle", 32'(busy), 32'(0));

        // abandoned burst on channel 2
        req = 4'b0100;
        burst_len = 4'd4;
        nvalid = 0;
        nlast = 0;
        step();
        chk("c.gnt", 32'(gnt), 32'(4'h4));
        chk("c.sel", 32'(sel), 32'(2'd2));
        step();
        nvalid += int'(out_valid);
        nlast += int'(out_last);
        req = 4'b0000;
        step();
        nvalid += int'(out_valid);
        nlast += int'(out_last);
        chk("c.busy", 32'(busy), 32'(0));
        chk("c.gnt0", 32'(gnt), 32'(0));
        step();
        nvalid += int'(out_valid);
        nlast += int'(out_last);
        chk("c.nvalid", 32'(nvalid), 32'(1));
        chk("c.nlast", 32'(nlast), 32'(0));

        // burst_len 0 acts as 1 on channel 3
        req = 4'b1000;
        burst_len = 4'd0;
        step();
        chk_out("d.c1", 4'h8, 2'd3, 1'b1, 1'b0, 2'd2, 1'b0);
        step();
        chk_out("d.c2", 4'h0, 2'd3, 1'b0, 1'b1, 2'd3, 1'b1);
        req = 4'b0000;
        step();

        // burst_len change mid-burst does not stretch it
        req = 4'b0001;
        burst_len = 4'd2;
        step();
        chk("e.gnt", 32'(gnt), 32'(4'h1));
        burst_len = 4'd5;
        step();
        chk_out("e.c2", 4'h1, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk_out("e.c3", 4'h0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1);
        req = 4'b0000;
        step();
        chk("e.ov", 32'(out_valid), 32'(0));

        // reset in the middle of a channel 1 burst
        req = 4'b0010;
        burst_len = 4'd4;
        step();
        chk("f.gnt", 32'(gnt), 32'(4'h2));
        step();
        chk("f.ov", 32'(out_valid), 32'(1));
        rst = 1'b1;
        step();
        chk_out("f.rst", 4'h0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        req = 4'b0011;
        burst_len = 4'd1;
        step();
        chk_out("f.first", 4'h1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        step();
        chk_out("f.done", 4'h0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1);
        req = 4'b0000;
        step();

        // no preemption: channel 1 waits for channel 0 plus a bubble
        req = 4'b0001;
        burst_len = 4'd2;
        step();
        chk("g.gnt1", 32'(gnt), 32'(4'h1));
        req = 4'b0011;
        step();
        chk("g.gnt2", 32'(gnt), 32'(4'h1));
        chk("g.sel2", 32'(sel), 32'(2'd0));
        step();
        chk_out("g.bub", 4'h0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1);
        step();
        chk("g.gnt4", 32'(gnt), 32'(4'h2));
        chk("g.sel4", 32'(sel), 32'(2'd1));
        req = 4'b0000;
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
